// File: rtl/sticky_pkg.sv
// sticky_pkg: shared state type and helper functions for sticky_flag_reader
package sticky_pkg;
  typedef enum logic {IDLE, RESP} state_t;
  function automatic int sat_max(input int w);
    return (1 << w) - 1;
  endfunction
  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int k = 0; k < 64; k++) c += int'(v[k]);
    return c;
  endfunction
endpackage

// File: rtl/sticky_bit.sv
// sticky_bit: one sticky flag, set wins over clear, reports collisions with a held flag
module sticky_bit (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic clr,
  output logic q,
  output logic coll
);
  assign coll = set & q & ~clr;
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= 1'b0;
    else q <= set ? 1'b1 : clr ? 1'b0 : q;
endmodule

// File: rtl/sticky_flag_reader.sv
// sticky_flag_reader: sticky event flags with read-and-clear snapshot port and drop counter
module sticky_flag_reader
  import sticky_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     evt_i,
  input  logic [N-1:0]     irq_en,
  input  logic             req_valid,
  output logic             req_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [N-1:0]     rsp_flags,
  output logic [CNT_W-1:0] rsp_drop_cnt,
  output logic             irq
);
  localparam int MAX = sat_max(CNT_W);
  state_t r_state, w_next;
  logic [N-1:0] w_flags, w_coll;
  logic [CNT_W-1:0] r_drop_cnt;
  logic w_accept;
  int w_sum;
  for (genvar g = 0; g < N; g++) begin : g_bit
    sticky_bit u_bit (
      .clk  (clk),
      .rst  (rst),
      .set  (evt_i[g]),
      .clr  (w_accept),
      .q    (w_flags[g]),
      .coll (w_coll[g])
    );
  end
  assign irq = |(w_flags & irq_en);
  always_comb begin
    req_ready = (r_state == IDLE) & ~rst;
    rsp_valid = r_state == RESP;
    w_accept  = req_valid & req_ready;
    w_next    = w_accept ? RESP : (rsp_valid & rsp_ready) ? IDLE : r_state;
    w_sum     = int'(r_drop_cnt) + popcount(64'(w_coll));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_drop_cnt <= '0;
    else r_drop_cnt <= w_accept ? '0 : (w_sum > MAX) ? CNT_W'(MAX) : CNT_W'(w_sum);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_flags    <= '0;
      rsp_drop_cnt <= '0;
    end else if (w_accept) begin
      rsp_flags    <= w_flags;
      rsp_drop_cnt <= r_drop_cnt;
    end
endmodule
